// File: rtl/stopwatch_ctrl.sv
// Run/pause/lap/idle controller for a 00..99 one-second BCD counter.
// It generates the count tick and drives two active-low 7-segment digits.
module stopwatch_ctrl #(
    parameter int unsigned CLK_DIV  = 50000000,
    parameter int unsigned MAX_TENS = 9
) (
    input  logic       clk_sys,
    input  logic       clr,
    input  logic       btn_ss,
    input  logic       btn_lap,
    output logic       run,
    output logic       lap_hold,
    output logic       RCO,
    output logic [3:0] cnt_tens,
    output logic [3:0] cnt_ones,
    output logic [6:0] Y_tens,
    output logic [6:0] Y_ones
);

    localparam int unsigned PRE_W = $clog2(CLK_DIV);
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_DIV - 1);
    localparam logic [3:0] TENS_MAX = 4'(MAX_TENS);
    localparam logic [6:0] SEG_ZERO = 7'b1000000;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_LAP   = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic             ss_prev_q, lap_prev_q;
    logic [PRE_W-1:0] presc_q, presc_d;
    logic [3:0]       tens_q, tens_d, ones_q, ones_d;
    logic [3:0]       snap_tens_q, snap_tens_d, snap_ones_q, snap_ones_d;
    logic             rco_q, rco_d;
    logic [6:0]       y_tens_q, y_tens_d, y_ones_q, y_ones_d;

    logic             press_ss, press_lap;
    logic             counting, tick, wrap, clear;
    logic [3:0]       disp_tens, disp_ones;

    // Active-low gfedcba segment pattern; anything outside 0..9 blanks.
    function automatic logic [6:0] seg7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    assign press_ss  = btn_ss & ~ss_prev_q;
    assign press_lap = btn_lap & ~lap_prev_q;

    // State register; clr reloads prev from the live button level.
    always_ff @(posedge clk_sys) begin
        ss_prev_q  <= btn_ss;
        lap_prev_q <= btn_lap;
        if (clr) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: start/stop takes priority over lap on a simultaneous press.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (press_ss) state_d = S_RUN;
            end
            S_RUN: begin
                if (press_ss)       state_d = S_PAUSE;
                else if (press_lap) state_d = S_LAP;
            end
            S_LAP: begin
                if (press_ss)       state_d = S_PAUSE;
                else if (press_lap) state_d = S_RUN;
            end
            S_PAUSE: begin
                if (press_ss)       state_d = S_RUN;
                else if (press_lap) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Status outputs decoded straight from the state register.
    always_comb begin
        run      = 1'b0;
        lap_hold = 1'b0;
        case (state_q)
            S_RUN: run = 1'b1;
            S_LAP: begin
                run      = 1'b1;
                lap_hold = 1'b1;
            end
            default: begin
                run      = 1'b0;
                lap_hold = 1'b0;
            end
        endcase
    end

    // Prescaler, BCD count, snapshot and display next values.
    always_comb begin
        counting    = (state_q == S_RUN) || (state_q == S_LAP);
        tick        = counting && (presc_q == PRE_MAX);
        wrap        = tick && (tens_q == TENS_MAX) && (ones_q == 4'd9);
        clear       = (state_q == S_IDLE) || ((state_q == S_PAUSE) && (state_d == S_IDLE));

        presc_d     = presc_q;
        tens_d      = tens_q;
        ones_d      = ones_q;
        snap_tens_d = snap_tens_q;
        snap_ones_d = snap_ones_q;
        rco_d       = wrap;

        if (clear) begin
            presc_d = '0;
            tens_d  = 4'd0;
            ones_d  = 4'd0;
        end else if (counting) begin
            presc_d = tick ? '0 : presc_q + 1'b1;
            if (tick) begin
                if (ones_q == 4'd9) begin
                    ones_d = 4'd0;
                    tens_d = (tens_q == TENS_MAX) ? 4'd0 : tens_q + 4'd1;
                end else begin
                    ones_d = ones_q + 4'd1;
                end
            end
        end

        // Snapshot captures the post-tick count on the RUN->LAP edge.
        if ((state_q == S_RUN) && (state_d == S_LAP)) begin
            snap_tens_d = tens_d;
            snap_ones_d = ones_d;
        end

        disp_tens = (state_q == S_LAP) ? snap_tens_q : tens_q;
        disp_ones = (state_q == S_LAP) ? snap_ones_q : ones_q;
        y_tens_d  = seg7(disp_tens);
        y_ones_d  = seg7(disp_ones);
    end

    always_ff @(posedge clk_sys) begin
        if (clr) begin
            presc_q     <= '0;
            tens_q      <= 4'd0;
            ones_q      <= 4'd0;
            snap_tens_q <= 4'd0;
            snap_ones_q <= 4'd0;
            rco_q       <= 1'b0;
            y_tens_q    <= SEG_ZERO;
            y_ones_q    <= SEG_ZERO;
        end else begin
            presc_q     <= presc_d;
            tens_q      <= tens_d;
            ones_q      <= ones_d;
            snap_tens_q <= snap_tens_d;
            snap_ones_q <= snap_ones_d;
            rco_q       <= rco_d;
            y_tens_q    <= y_tens_d;
            y_ones_q    <= y_ones_d;
        end
    end

    assign RCO      = rco_q;
    assign cnt_tens = tens_q;
    assign cnt_ones = ones_q;
    assign Y_tens   = y_tens_q;
    assign Y_ones   = y_ones_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with a 4-cycle tick.
module tb_stopwatch_ctrl;

    localparam int unsigned CLK_DIV  = 4;
    localparam int unsigned MAX_TENS = 9;

    localparam logic [6:0] SEG0 = 7'b1000000;
    localparam logic [6:0] SEG1 = 7'b1111001;
    localparam logic [6:0] SEG3 = 7'b0110000;
    localparam logic [6:0] SEG5 = 7'b0010010;
    localparam logic [6:0] SEG7 = 7'b1111000;
    localparam logic [6:0] SEG9 = 7'b0010000;

    logic       clk_sys;
    logic       clr;
    logic       btn_ss;
    logic       btn_lap;
    logic       run;
    logic       lap_hold;
    logic       RCO;
    logic [3:0] cnt_tens;
    logic [3:0] cnt_ones;
    logic [6:0] Y_tens;
    logic [6:0] Y_ones;

    int n_checks = 0;
    int n_fails  = 0;

    stopwatch_ctrl #(
        .CLK_DIV (CLK_DIV),
        .MAX_TENS(MAX_TENS)
    ) dut (
        .clk_sys (clk_sys),
        .clr     (clr),
        .btn_ss  (btn_ss),
        .btn_lap (btn_lap),
        .run     (run),
        .lap_hold(lap_hold),
        .RCO     (RCO),
        .cnt_tens(cnt_tens),
        .cnt_ones(cnt_ones),
        .Y_tens  (Y_tens),
        .Y_ones  (Y_ones)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic press(input logic ss, input logic lap);
        btn_ss  = ss;
        btn_lap = lap;
        step(1);
        btn_ss  = 1'b0;
        btn_lap = 1'b0;
    endtask

    task automatic do_reset();
        clr = 1'b1;
        step(2);
        clr = 1'b0;
    endtask

    task automatic wait_count(input string tag, input logic [7:0] target, input int budget);
        int waited;
        waited = 0;
        while (({cnt_tens, cnt_ones} != target) && (waited < budget)) begin
            step(1);
            waited++;
        end
        check_eq(tag, 32'({cnt_tens, cnt_ones}), 32'(target));
    endtask

    initial begin
        clr     = 1'b0;
        btn_ss  = 1'b0;
        btn_lap = 1'b0;
        step(1);
        do_reset();

        check_eq("rst_run",   32'(run),      32'd0);
        check_eq("rst_lap",   32'(lap_hold), 32'd0);
        check_eq("rst_rco",   32'(RCO),      32'd0);
        check_eq("rst_cnt",   32'({cnt_tens, cnt_ones}), 32'h00);
        check_eq("rst_ytens", 32'(Y_tens),   32'(SEG0));
        check_eq("rst_yones", 32'(Y_ones),   32'(SEG0));

        // Start: first increment CLK_DIV edges after the press edge
        press(1'b1, 1'b0);
        check_eq("start_run", 32'(run), 32'd1);
        step(3);
        check_eq("pre_tick_cnt", 32'(cnt_ones), 32'd0);
        step(1);
        check_eq("tick1_cnt",  32'(cnt_ones), 32'd1);
        check_eq("tick1_yold", 32'(Y_ones),   32'(SEG0));
        step(1);
        check_eq("tick1_y",    32'(Y_ones),   32'(SEG1));
        step(3);
        check_eq("tick2_cnt",  32'(cnt_ones), 32'd2);

        // Wrap 99 -> 00 with a single-cycle RCO
        wait_count("reach_99", 8'h99, 500);
        step(3);
        check_eq("pre_wrap_cnt", 32'({cnt_tens, cnt_ones}), 32'h99);
        check_eq("pre_wrap_rco", 32'(RCO), 32'd0);
        step(1);
        check_eq("wrap_cnt",   32'({cnt_tens, cnt_ones}), 32'h00);
        check_eq("wrap_rco",   32'(RCO), 32'd1);
        check_eq("wrap_yold",  32'(Y_ones), 32'(SEG9));
        step(1);
        check_eq("post_wrap_rco", 32'(RCO),    32'd0);
        check_eq("wrap_ytens",    32'(Y_tens), 32'(SEG0));
        check_eq("wrap_yones",    32'(Y_ones), 32'(SEG0));

        // Lap hold at 05, counting continues underneath
        do_reset();
        press(1'b1, 1'b0);
        step(20);
        check_eq("lap_pre_cnt", 32'(cnt_ones), 32'd5);
        step(1);
        press(1'b0, 1'b1);
        check_eq("lap_hold_on", 32'(lap_hold), 32'd1);
        check_eq("lap_run_on",  32'(run),      32'd1);
        step(6);
        check_eq("lap_live_cnt", 32'(cnt_ones), 32'd7);
        check_eq("lap_frozen_y", 32'(Y_ones),   32'(SEG5));
        press(1'b0, 1'b1);
        check_eq("lap_release",  32'(lap_hold), 32'd0);
        check_eq("lap_rel_yold", 32'(Y_ones),   32'(SEG5));
        step(1);
        check_eq("lap_rel_y",    32'(Y_ones),   32'(SEG7));

        // Pause 10 cycles mid-second: next tick moves 10 cycles later
        press(1'b1, 1'b0);
        check_eq("pause_run", 32'(run), 32'd0);
        step(9);
        check_eq("pause_hold_cnt", 32'(cnt_ones), 32'd7);
        press(1'b1, 1'b0);
        check_eq("resume_run", 32'(run),      32'd1);
        check_eq("resume_cnt", 32'(cnt_ones), 32'd7);
        step(1);
        check_eq("resume_tick", 32'(cnt_ones), 32'd8);

        // PAUSE + lap returns to IDLE with count cleared
        press(1'b1, 1'b0);
        press(1'b0, 1'b1);
        check_eq("idle_cnt", 32'({cnt_tens, cnt_ones}), 32'h00);
        check_eq("idle_run", 32'(run), 32'd0);
        step(1);
        check_eq("idle_y", 32'(Y_ones), 32'(SEG0));
        press(1'b0, 1'b1);
        step(6);
        check_eq("idle_lap_ignored", 32'(run), 32'd0);

        // Simultaneous presses in RUN: start/stop wins
        press(1'b1, 1'b0);
        step(12);
        check_eq("simul_pre_cnt", 32'(cnt_ones), 32'd3);
        press(1'b1, 1'b1);
        check_eq("simul_run", 32'(run),      32'd0);
        check_eq("simul_lap", 32'(lap_hold), 32'd0);
        step(1);
        check_eq("simul_y",   32'(Y_ones),   32'(SEG3));
        step(5);
        check_eq("simul_hold", 32'(cnt_ones), 32'd3);

        // Buttons held through clr never register as presses
        btn_ss  = 1'b1;
        btn_lap = 1'b1;
        do_reset();
        step(3);
        check_eq("held_run", 32'(run),      32'd0);
        check_eq("held_lap", 32'(lap_hold), 32'd0);
        btn_ss  = 1'b0;
        btn_lap = 1'b0;
        step(1);
        press(1'b1, 1'b0);
        check_eq("held_then_start", 32'(run), 32'd1);

        // clr in LAP restores every reset value on the next edge
        step(9);
        press(1'b0, 1'b1);
        check_eq("pre_clr_lap", 32'(lap_hold), 32'd1);
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        check_eq("clr_run",   32'(run),      32'd0);
        check_eq("clr_lap",   32'(lap_hold), 32'd0);
        check_eq("clr_rco",   32'(RCO),      32'd0);
        check_eq("clr_cnt",   32'({cnt_tens, cnt_ones}), 32'h00);
        check_eq("clr_ytens", 32'(Y_tens),   32'(SEG0));
        check_eq("clr_yones", 32'(Y_ones),   32'(SEG0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
